c2hdl_mem_arbiter: RTL and testbench
====================================

Name: c2hdl_mem_arbiter

Overview:
- Shares one c2hdl-style memory port (addr/size/valid/write/wdata/rdata/ready) between NREQ generated cores, e.g. two kernel instances on one RAM.
- Round-robin grant; one outstanding transaction at a time.
- Sits between the core memory ports and the single RAM/bus port.
- The RAM returns ready one cycle after valid and may raise a stale ready for one cycle after valid drops; the arbiter absorbs it.

Parameters:
- NREQ, 2, number of requesting cores (2..8)
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- m_addr  in  NREQ*AW  per-requester address, requester i at [i*AW +: AW]
- m_size  in  NREQ*3  per-requester size: 0=byte, 1=half, 2=word
- m_valid  in  NREQ  request; held with fields stable until that requester's m_ready pulse
- m_write  in  NREQ  1=write, 0=read
- m_wdata  in  NREQ*DW  write data
- m_rdata  out  DW  read data, shared by all requesters; valid while the granted requester's m_ready is high
- m_ready  out  NREQ  one-cycle completion pulse, one-hot or zero
- s_addr  out  AW  RAM address
- s_size  out  3  RAM size
- s_valid  out  1  RAM request
- s_write  out  1  RAM write
- s_wdata  out  DW  RAM write data
- s_rdata  in  DW  RAM read data
- s_ready  in  1  RAM completion
- grant  out  NREQ  current owner, one-hot; zero in ARB
- busy  out  1  high in BUSY or RESP

Behaviour:
- Reset values:
  - state=ARB; grant=0; m_ready=0; m_rdata=0; s_valid=0.
  - s_addr, s_size, s_write, s_wdata=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- ARB:
  - If any m_valid is set, pick the first set bit searching from last+1 upward, wrapping modulo NREQ.
  - Register grant, last and the selected request fields onto the s_* outputs; set s_valid<=1 and go to BUSY.
  - If no m_valid is set, stay in ARB.
  - s_ready is ignored in ARB.
- BUSY:
  - s_* outputs are held from registers; requester inputs are not re-sampled.
  - On s_ready=1: s_valid<=0, m_rdata<=s_rdata (also on writes), m_ready[grant]<=1, go to RESP.
  - A requester dropping m_valid mid-transaction is a protocol violation. The transaction still completes and the pulse is still issued.
- RESP:
  - Lasts exactly one cycle; m_ready<=0, grant<=0, go to ARB.
  - Stale s_ready in this cycle is ignored.
  - The requester updates m_valid at the edge where it sees m_ready, so ARB samples fresh requests.
- Latency:
  - Request seen in ARB at cycle t: s_valid at t+1, s_ready at t+2 (1-cycle RAM), m_ready high in t+3.
  - Next arbitration at t+4; a transaction occupies 4 cycles.
- Fairness: with all requesters continuously valid, grant sequence is 0,1,…,NREQ-1,0… with no starvation.
- m_rdata holds its value after RESP until the next completion.
- Reset mid-transaction: everything returns to reset values immediately; the in-flight transaction is lost and no m_ready is issued.

Optional Feature:
- Macro: C2HDL_ARB_LOCK_EN
- With the macro:
  - Adds input m_lock [NREQ].
  - If the granted requester's m_lock is 1 in RESP, arbitration is bypassed: the next ARB cycle regrants the same requester if its m_valid is set, and last is not advanced.
  - If m_valid is clear, normal round-robin applies.
  - Used for atomic read-modify-write sequences.
- Without the macro: port absent, pure round-robin.

Decomposition:
- Package c2hdl_bus_pkg:
  - size constants SZ_BYTE=3'd0, SZ_HALF=3'd1, SZ_WORD=3'd2
  - state enum {ARB, BUSY, RESP}
- Sub-module c2hdl_rr_pick: combinational; inputs req [NREQ] and last index; outputs one-hot gnt and its index.

Test Plan:
- Single reader: requester 0 reads 0x1100, RAM holds bytes "shit" (0x74696873 LE) -> s_valid one cycle after request, m_ready[0] pulse 3 cycles after request, m_rdata=0x74696873, m_ready[1] stays 0.
- Contention: both valid in the same cycle, last=1 -> requester 0 served first, then requester 1; exactly one m_ready per transaction, 8 cycles total.
- Sustained contention, 6 transactions each requester -> grant alternates 0,1,0,1…; the RAM sees 12 s_valid rising edges.
- Write pass-through: requester 1 writes size=0, addr 0x1204, wdata 0x21 -> RAM byte 0x1204=0x21, neighbouring bytes unchanged, s_size=0.
- Stale-ready: RAM keeps ready<=valid -> no spurious m_ready and no double completion across 20 back-to-back transactions.
- Reset asserted in BUSY -> s_valid, grant, m_ready go 0 asynchronously; after release, the first grant goes to requester 0.
- With C2HDL_ARB_LOCK_EN: requester 1 locked for 3 transactions while requester 0 is valid -> grant 1,1,1 then 0.

Source files
------------

// File: rtl/c2hdl_bus_pkg.sv
// -----------------------------------------------------------------------------
// c2hdl_bus_pkg : shared size codes and arbiter state encoding
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package c2hdl_bus_pkg;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/c2hdl_rr_pick.sv
// -----------------------------------------------------------------------------
// c2hdl_rr_pick : combinational round-robin picker, searches upward from last+1
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module c2hdl_rr_pick
  import c2hdl_bus_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/c2hdl_mem_arbiter.sv
// -----------------------------------------------------------------------------
// c2hdl_mem_arbiter : round-robin sharing of one RAM port between NREQ cores.
// Optional C2HDL_ARB_LOCK_EN adds m_lock to regrant the same core back-to-back.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module c2hdl_mem_arbiter
  import c2hdl_bus_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [NREQ*AW-1:0] m_addr,
  input  logic [NREQ*3-1:0] m_size,
  input  logic [NREQ-1:0]   m_valid,
  input  logic [NREQ-1:0]   m_write,
  input  logic [NREQ*DW-1:0] m_wdata,
`ifdef C2HDL_ARB_LOCK_EN
  input  logic [NREQ-1:0]   m_lock,
`endif
  output logic [DW-1:0]     m_rdata,
  output logic [NREQ-1:0]   m_ready,
  output logic [AW-1:0]     s_addr,
  output logic [2:0]        s_size,
  output logic              s_valid,
  output logic              s_write,
  output logic [DW-1:0]     s_wdata,
  input  logic [DW-1:0]     s_rdata,
  input  logic              s_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] m_ready_q, m_ready_d;
  logic [DW-1:0]   m_rdata_q, m_rdata_d;
  logic [AW-1:0]   s_addr_q, s_addr_d;
  logic [2:0]      s_size_q, s_size_d;
  logic            s_valid_q, s_valid_d;
  logic            s_write_q, s_write_d;
  logic [DW-1:0]   s_wdata_q, s_wdata_d;

  logic [NREQ-1:0] pick_gnt, sel_gnt;
  logic [IW-1:0]   pick_idx, sel_idx;

  c2hdl_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req  (m_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

`ifdef C2HDL_ARB_LOCK_EN
  logic lock_q, lock_d;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    m_ready_d = m_ready_q;
    m_rdata_d = m_rdata_q;
    s_addr_d  = s_addr_q;
    s_size_d  = s_size_q;
    s_valid_d = s_valid_q;
    s_write_d = s_write_q;
    s_wdata_d = s_wdata_q;
    sel_gnt   = pick_gnt;
    sel_idx   = pick_idx;
`ifdef C2HDL_ARB_LOCK_EN
    lock_d    = lock_q;
    // last_q still names the previous owner, so a lock just re-selects it
    if (lock_q && m_valid[last_q]) begin
      sel_gnt          = '0;
      sel_gnt[last_q]  = 1'b1;
      sel_idx          = last_q;
    end
`endif

    case (state_q)
      ARB: begin
`ifdef C2HDL_ARB_LOCK_EN
        lock_d = 1'b0;
`endif
        if (|m_valid) begin
          grant_d   = sel_gnt;
          last_d    = sel_idx;
          s_addr_d  = m_addr[sel_idx*AW +: AW];
          s_size_d  = m_size[sel_idx*3 +: 3];
          s_write_d = m_write[sel_idx];
          s_wdata_d = m_wdata[sel_idx*DW +: DW];
          s_valid_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ready) begin
          s_valid_d = 1'b0;
          m_rdata_d = s_rdata;
          m_ready_d = grant_q;
          state_d   = RESP;
        end
      end
      RESP: begin
        // RAM may still hold s_ready high here; it is deliberately not looked at
        m_ready_d = '0;
        grant_d   = '0;
        state_d   = ARB;
`ifdef C2HDL_ARB_LOCK_EN
        lock_d    = m_lock[last_q];
`endif
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ARB;
      grant_q   <= '0;
      last_q    <= IW'(NREQ - 1);
      m_ready_q <= '0;
      m_rdata_q <= '0;
      s_addr_q  <= '0;
      s_size_q  <= '0;
      s_valid_q <= 1'b0;
      s_write_q <= 1'b0;
      s_wdata_q <= '0;
`ifdef C2HDL_ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      m_ready_q <= m_ready_d;
      m_rdata_q <= m_rdata_d;
      s_addr_q  <= s_addr_d;
      s_size_q  <= s_size_d;
      s_valid_q <= s_valid_d;
      s_write_q <= s_write_d;
      s_wdata_q <= s_wdata_d;
`ifdef C2HDL_ARB_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

  assign m_rdata = m_rdata_q;
  assign m_ready = m_ready_q;
  assign s_addr  = s_addr_q;
  assign s_size  = s_size_q;
  assign s_valid = s_valid_q;
  assign s_write = s_write_q;
  assign s_wdata = s_wdata_q;
  assign grant   = grant_q;
  assign busy    = (state_q != ARB);

endmodule

`default_nettype wire

// File: tb/tb_c2hdl_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_c2hdl_mem_arbiter : directed + random checks against a byte-array RAM model
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_c2hdl_mem_arbiter;
  import c2hdl_bus_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ*AW-1:0] m_addr;
  logic [NREQ*3-1:0]  m_size;
  logic [NREQ-1:0]    m_valid, m_write, m_lock;
  logic [NREQ*DW-1:0] m_wdata;
  logic [DW-1:0]      m_rdata;
  logic [NREQ-1:0]    m_ready, grant;
  logic [AW-1:0]      s_addr;
  logic [2:0]         s_size;
  logic               s_valid, s_write, s_ready, busy;
  logic [DW-1:0]      s_wdata, s_rdata;

  c2hdl_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .m_addr  (m_addr),
    .m_size  (m_size),
    .m_valid (m_valid),
    .m_write (m_write),
    .m_wdata (m_wdata),
`ifdef C2HDL_ARB_LOCK_EN
    .m_lock  (m_lock),
`endif
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .s_addr  (s_addr),
    .s_size  (s_size),
    .s_valid (s_valid),
    .s_write (s_write),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ready (s_ready),
    .grant   (grant),
    .busy    (busy)
  );

  // Initial RAM image; 0x1100..0x1103 spell "shit"
  function automatic logic [7:0] init_byte(int a);
    case (a)
      32'h1100: return 8'h73;
      32'h1101: return 8'h68;
      32'h1102: return 8'h69;
      32'h1103: return 8'h74;
      default:  return 8'((a * 37) ^ (a >> 3));
    endcase
  endfunction

  // RAM: ready one cycle after valid, so ready lingers one cycle after valid drops
  logic [7:0] ram [0:4095];
  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s_ready <= 1'b0;
      s_rdata <= '0;
      for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i | 32'h1000);
    end else begin
      s_ready <= s_valid;
      if (s_valid && !s_ready) begin
        s_rdata <= {ram[{s_addr[11:2], 2'd3}], ram[{s_addr[11:2], 2'd2}],
                    ram[{s_addr[11:2], 2'd1}], ram[{s_addr[11:2], 2'd0}]};
        if (s_write) begin
          case (s_size)
            SZ_BYTE: ram[s_addr[11:0]] <= s_wdata[7:0];
            SZ_HALF: begin
              ram[{s_addr[11:1], 1'b0}] <= s_wdata[7:0];
              ram[{s_addr[11:1], 1'b1}] <= s_wdata[15:8];
            end
            default: begin
              ram[{s_addr[11:2], 2'd0}] <= s_wdata[7:0];
              ram[{s_addr[11:2], 2'd1}] <= s_wdata[15:8];
              ram[{s_addr[11:2], 2'd2}] <= s_wdata[23:16];
              ram[{s_addr[11:2], 2'd3}] <= s_wdata[31:24];
            end
          endcase
        end
      end
    end
  end

  int cyc = 0;
  int rises = 0;
  logic sv_prev = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    sv_prev <= s_valid;
    if (s_valid && !sv_prev) rises <= rises + 1;
  end

  // Requester-side stimulus and the reference model state
  logic [AW-1:0] r_addr  [NREQ];
  logic [2:0]    r_size  [NREQ];
  logic          r_write [NREQ];
  logic [DW-1:0] r_wdata [NREQ];
  logic          r_valid [NREQ];
  logic          r_lock  [NREQ];
  logic [7:0]    shadow  [0:4095];
  int            last_m;
  logic          lock_m;
  int            npass = 0;
  int            ntotal = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      m_addr[i*AW +: AW]  = r_addr[i];
      m_size[i*3 +: 3]    = r_size[i];
      m_write[i]          = r_write[i];
      m_wdata[i*DW +: DW] = r_wdata[i];
      m_valid[i]          = r_valid[i];
      m_lock[i]           = r_lock[i];
    end
  endtask

  task automatic set_req(int i, logic wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
    r_valid[i] = 1'b1; r_write[i] = wr; r_size[i] = sz; r_addr[i] = a; r_wdata[i] = wd;
  endtask

  task automatic rand_req(int i);
    logic [2:0]  sz;
    logic [31:0] a;
    sz = 3'($urandom_range(0, 2));
    a  = 32'h1000 | ($urandom & 32'hfff);
    a  = a & ~((32'd1 << sz) - 32'd1);
    set_req(i, 1'($urandom & 1), sz, a, $urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) shadow[i] = init_byte(i | 32'h1000);
    last_m = NREQ - 1;
    lock_m = 1'b0;
  endtask

  function automatic logic [31:0] sh_word(logic [31:0] a);
    int b;
    b = int'(a[11:0]) & ~3;
    return {shadow[b+3], shadow[b+2], shadow[b+1], shadow[b]};
  endfunction

  task automatic sh_write(logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
    int b, n;
    n = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    b = int'(a[11:0]) & ~(n - 1);
    for (int k = 0; k < n; k++) shadow[b+k] = wd[8*k +: 8];
  endtask

  // Round-robin from the spec: first valid after the last owner, wrapping
  function automatic int pick_model();
    if (lock_m && r_valid[last_m]) return last_m;
    for (int k = 1; k <= NREQ; k++)
      if (r_valid[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
    return -1;
  endfunction

  // Entered in an ARB cycle with requests driven; returns in the next ARB cycle
  task automatic do_round(output int who);
    int e, cnt;
    logic [31:0] exp_rd;
    e = pick_model();
    who = e;
    if (e < 0) begin
      check("no_requester", 64'd1, 64'd0);
      return;
    end
    exp_rd = sh_word(r_addr[e]);
    if (r_write[e]) sh_write(r_size[e], r_addr[e], r_wdata[e]);
    last_m = e;
    @(posedge clk); #1;
    check("s_valid_t1", 64'(s_valid), 64'd1);
    check("grant_busy", 64'(grant), 64'(1 << e));
    check("s_addr", 64'(s_addr), 64'(r_addr[e]));
    check("s_size", 64'(s_size), 64'(r_size[e]));
    check("s_write", 64'(s_write), 64'(r_write[e]));
    if (r_write[e]) check("s_wdata", 64'(s_wdata), 64'(r_wdata[e]));
    cnt = 1;
    while (m_ready == '0 && cnt < 8) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("ready_latency", 64'(cnt), 64'd3);
    check("m_ready_onehot", 64'(m_ready), 64'(1 << e));
    check("m_rdata", 64'(m_rdata), 64'(exp_rd));
    check("grant_resp", 64'(grant), 64'(1 << e));
    lock_m = r_lock[e];
    r_valid[e] = 1'b0;
    drive();
    @(posedge clk); #1;
    check("no_double_ready", 64'(m_ready), 64'd0);
    check("grant_arb", 64'(grant), 64'd0);
  endtask

  initial begin
    int who, c0, r0, nr;
    for (int i = 0; i < NREQ; i++) begin
      r_valid[i] = 0; r_lock[i] = 0; r_write[i] = 0; r_size[i] = 0;
      r_addr[i] = 0; r_wdata[i] = 0;
    end
    drive();
    model_reset();
    #2 rstb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rstb = 1'b1;
    @(posedge clk); #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_m_ready", 64'(m_ready), 64'd0);
    check("rst_m_rdata", 64'(m_rdata), 64'd0);
    check("rst_s_valid", 64'(s_valid), 64'd0);
    check("rst_s_addr", 64'(s_addr), 64'd0);
    check("rst_s_fields", 64'({s_size, s_write}), 64'd0);
    check("rst_s_wdata", 64'(s_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Single reader of "shit"
    set_req(0, 1'b0, SZ_WORD, 32'h1100, 32'd0);
    drive();
    do_round(who);
    check("single_who", 64'(who), 64'd0);
    check("single_rdata", 64'(m_rdata), 64'h74696873);

    // Byte write by requester 1
    set_req(1, 1'b1, SZ_BYTE, 32'h1204, 32'h21);
    drive();
    do_round(who);
    check("wr_who", 64'(who), 64'd1);
    check("wr_byte", 64'(ram[12'h204]), 64'h21);
    check("wr_below", 64'(ram[12'h203]), 64'(init_byte(32'h1203)));
    check("wr_above", 64'(ram[12'h205]), 64'(init_byte(32'h1205)));
    check("rdata_hold", 64'(m_rdata), 64'(sh_word(32'h1204) & 32'hffffff00 | 32'(init_byte(32'h1204))));

    // Contention with last=1: 0 then 1, 8 cycles
    rand_req(0); rand_req(1);
    drive();
    c0 = cyc;
    do_round(who);
    check("cont_first", 64'(who), 64'd0);
    do_round(who);
    check("cont_second", 64'(who), 64'd1);
    check("cont_cycles", 64'(cyc - c0), 64'd8);

    // Sustained contention: strict alternation
    r0 = rises;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NREQ; i++) if (!r_valid[i]) rand_req(i);
      drive();
      do_round(who);
      check("alt_grant", 64'(who), 64'(n % 2));
    end
    // Random occupancy back-to-back
    nr = 12;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NREQ; i++) if (!r_valid[i] && ($urandom_range(0, 3) != 0)) rand_req(i);
      if (!r_valid[0] && !r_valid[1]) rand_req(int'($urandom_range(0, NREQ - 1)));
      drive();
      do_round(who);
      nr++;
    end
    @(posedge clk); #1;
    check("s_valid_rises", 64'(rises - r0), 64'(nr));

    // Reset while BUSY
    for (int i = 0; i < NREQ; i++) r_valid[i] = 0;
    rand_req(0);
    drive();
    @(posedge clk); #1;
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rstb = 1'b0;
    #1;
    check("arst_s_valid", 64'(s_valid), 64'd0);
    check("arst_grant", 64'(grant), 64'd0);
    check("arst_m_ready", 64'(m_ready), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    rand_req(0); rand_req(1);
    drive();
    @(negedge clk) rstb = 1'b1;
    do_round(who);
    check("post_rst_first", 64'(who), 64'd0);

`ifdef C2HDL_ARB_LOCK_EN
    // Requester 1 locks across three grants while 0 waits
    rand_req(0); rand_req(1);
    r_lock[1] = 1'b1;
    drive();
    do_round(who);
    check("lock_g1", 64'(who), 64'd1);
    rand_req(1); drive();
    do_round(who);
    check("lock_g2", 64'(who), 64'd1);
    rand_req(1); r_lock[1] = 1'b0; drive();
    do_round(who);
    check("lock_g3", 64'(who), 64'd1);
    rand_req(1); drive();
    do_round(who);
    check("lock_then0", 64'(who), 64'd0);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire
